// File: rtl/shift_gearbox_pkg.sv
// Shared types for the shift gearbox: the FILL/DRAIN state enum and counter sizing.
package shift_gearbox_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } gbState_e;

    // Counters must reach max(NI, NO) without wrapping.
    function automatic int countWidth(input int ni, input int no);
        int m;
        m = (ni > no) ? ni : no;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/shift_gearbox_byte_swap.sv
// Combinational byte reversal of a W-bit word; compiled only when SHIFT_GEARBOX_BSWAP_EN is defined.
`ifdef SHIFT_GEARBOX_BSWAP_EN
module shift_gearbox_byte_swap #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    if ((W % 8) != 0) begin : gBadWidth
        $error("shift_gearbox_byte_swap: W must be a multiple of 8");
    end

    for (genvar i = 0; i < W / 8; i++) begin : gSwap
        assign data_o[8*i +: 8] = data_i[W-8-8*i +: 8];
    end

endmodule
`endif

// File: rtl/shift_gearbox.sv
// Width-converting shift gearbox: fills a DATA_W buffer with IN_W beats, then drains it as OUT_W beats.
// Define SHIFT_GEARBOX_BSWAP_EN to byte-reverse each output word.
module shift_gearbox
    import shift_gearbox_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 32,
    parameter int DATA_W = 640
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int NI = DATA_W / IN_W;
    localparam int NO = DATA_W / OUT_W;
    localparam int CW = countWidth(NI, NO);

    if ((DATA_W % IN_W) != 0 || (DATA_W % OUT_W) != 0) begin : gBadWidth
        $error("shift_gearbox: DATA_W must be a multiple of IN_W and of OUT_W");
    end

    gbState_e          state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [CW-1:0]     inCount_q, inCount_d;
    logic [CW-1:0]     outCount_q, outCount_d;
    logic [OUT_W-1:0]  outWord;
    logic              lastBeat;

    assign outWord  = buf_q[DATA_W-1 -: OUT_W];
    assign lastBeat = (state_q == DRAIN) && (outCount_q == CW'(NO - 1));

    // Clear masks both handshakes so a coincident transfer is never half-taken.
    assign in_ready  = (state_q == FILL)  && !clear;
    assign out_valid = (state_q == DRAIN) && !clear;
    assign out_last  = lastBeat && !clear;
    assign busy      = (state_q == DRAIN) || (inCount_q != '0);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        inCount_d  = inCount_q;
        outCount_d = outCount_q;
        if (clear) begin
            state_d    = FILL;
            buf_d      = '0;
            inCount_d  = '0;
            outCount_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        buf_d = (buf_q << IN_W) | DATA_W'(in_data);
                        if (inCount_q == CW'(NI - 1)) begin
                            state_d   = DRAIN;
                            inCount_d = '0;
                        end else begin
                            inCount_d = inCount_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        buf_d = buf_q << OUT_W;
                        if (lastBeat) begin
                            state_d    = FILL;
                            outCount_d = '0;
                        end else begin
                            outCount_d = outCount_q + CW'(1);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            buf_q      <= '0;
            inCount_q  <= '0;
            outCount_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            inCount_q  <= inCount_d;
            outCount_q <= outCount_d;
        end
    end

`ifdef SHIFT_GEARBOX_BSWAP_EN
    shift_gearbox_byte_swap #(
        .W(OUT_W)
    ) u_byte_swap (
        .data_i(outWord),
        .data_o(out_data)
    );
`else
    assign out_data = outWord;
`endif

endmodule

// File: tb/tb_shift_gearbox.sv
// Self-checking bench for shift_gearbox (IN_W=8, OUT_W=16, DATA_W=32) against a queue-based reference model.
// Honours SHIFT_GEARBOX_BSWAP_EN when deciding the expected output byte order.
module tb_shift_gearbox;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 16;
    localparam int DATA_W = 32;
    localparam int NI     = DATA_W / IN_W;
    localparam int NO     = DATA_W / OUT_W;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;

    int testsRun = 0;
    int testsFailed = 0;

    logic [IN_W-1:0]  fillQ[$];
    logic [OUT_W-1:0] outQ[$];
    logic [OUT_W-1:0] gotQ[$];

    shift_gearbox #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected word from two input bytes, first byte most significant.
    function automatic logic [OUT_W-1:0] mkWord(input logic [7:0] hi, input logic [7:0] lo);
`ifdef SHIFT_GEARBOX_BSWAP_EN
        return {lo, hi};
`else
        return {hi, lo};
`endif
    endfunction

    // One clock cycle: drive, check at the falling edge, then advance the model with the rising edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
        logic expOv;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        @(negedge clock);
        expOv = (outQ.size() != 0) && !clr;
        checkOutput("in_ready", 32'(in_ready), 32'((outQ.size() == 0) && !clr));
        checkOutput("out_valid", 32'(out_valid), 32'(expOv));
        checkOutput("busy", 32'(busy), 32'((outQ.size() != 0) || (fillQ.size() != 0)));
        checkOutput("out_last", 32'(out_last), 32'(expOv && (outQ.size() == 1)));
        if (expOv) begin
            checkOutput("out_data", 32'(out_data), 32'(outQ[0]));
            if (ordy) gotQ.push_back(out_data);
        end
        @(posedge clock);
        if (clr) begin
            fillQ.delete();
            outQ.delete();
        end else if (outQ.size() != 0) begin
            if (ordy) void'(outQ.pop_front());
        end else if (iv) begin
            fillQ.push_back(id);
            if (fillQ.size() == NI) begin
                for (int k = 0; k < NO; k++) outQ.push_back(mkWord(fillQ[2*k], fillQ[2*k+1]));
                fillQ.delete();
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic doReset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        fillQ.delete();
        outQ.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic feed4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        applyStimulus(1'b1, a, 1'b1, 1'b0);
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        applyStimulus(1'b1, c, 1'b1, 1'b0);
        applyStimulus(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic checkGot(input string tag, input logic [OUT_W-1:0] w0, input logic [OUT_W-1:0] w1);
        checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'd2);
        if (gotQ.size() >= 2) begin
            checkOutput({tag, "_w0"}, 32'(gotQ[0]), 32'(w0));
            checkOutput({tag, "_w1"}, 32'(gotQ[1]), 32'(w1));
        end
    endtask

    initial begin
        #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Back-to-back fill and drain; in_ready returns after the last beat.
        gotQ.delete();
        feed4(8'h11, 8'h22, 8'h33, 8'h44);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkGot("b2b", mkWord(8'h11, 8'h22), mkWord(8'h33, 8'h44));

        // Back-pressure holds the first word for three cycles.
        gotQ.delete();
        feed4(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkGot("stall", mkWord(8'h11, 8'h22), mkWord(8'h33, 8'h44));

        // Clear discards a partial fill.
        gotQ.delete();
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        feed4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkGot("clear", mkWord(8'hAA, 8'hBB), mkWord(8'hCC, 8'hDD));

        // Reset mid-drain throws away the remaining word.
        gotQ.delete();
        feed4(8'h11, 8'h22, 8'h33, 8'h44);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pre_reset_count", 32'(gotQ.size()), 32'd1);
        doReset();
        gotQ.delete();
        feed4(8'h01, 8'h02, 8'h03, 8'h04);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkGot("reset", mkWord(8'h01, 8'h02), mkWord(8'h03, 8'h04));

        // in_valid held during drain is not captured.
        gotQ.delete();
        feed4(8'h11, 8'h22, 8'h33, 8'h44);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        gotQ.delete();
        feed4(8'h66, 8'h77, 8'h88, 8'h99);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkGot("ignore", mkWord(8'h66, 8'h77), mkWord(8'h88, 8'h99));

        // Randomized traffic with sporadic clears and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 350) doReset();
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          8'($urandom()),
                          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
